// File: rtl/cfg_csh_bar_responder_pkg.sv
// Shared constants for the type-0 configuration header responder:
// header byte addresses, response status codes, FSM encoding and BAR encodings.
package cfg_csh_bar_responder_pkg;

  localparam logic [11:0] CSH_CMD     = 12'h004;
  localparam logic [11:0] CSH_BAR0_LO = 12'h010;
  localparam logic [11:0] CSH_BAR0_HI = 12'h014;
  localparam logic [11:0] CSH_BAR1_LO = 12'h018;
  localparam logic [11:0] CSH_BAR1_HI = 12'h01C;
  localparam logic [11:0] CSH_BAR2_LO = 12'h020;
  localparam logic [11:0] CSH_BAR2_HI = 12'h024;
  localparam logic [11:0] CSH_SUBSYS  = 12'h02C;
  localparam logic [11:0] CSH_EXP_ROM = 12'h030;

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_UNSUP = 2'd1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } csh_state_e;

  localparam logic [1:0]  BAR_TYPE_64 = 2'b10;
  localparam logic [63:0] BAR_UNIMPL  = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/cfg_csh_bar_reg.sv
// One 64-bit memory BAR: stores the base masked by the size at write time
// and presents the low/high header dwords for reads.
module cfg_csh_bar_reg
  import cfg_csh_bar_responder_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] size,
  input  logic        prefetchable,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [63:0] base,
  output logic [31:0] rd_lo,
  output logic [31:0] rd_hi
);

  logic        unimpl;
  logic [63:0] base_nxt;

  assign unimpl = (size == BAR_UNIMPL);

  always_comb begin
    base_nxt = base;
    for (int b = 0; b < 4; b++) begin
      if (wr_lo && be[b]) base_nxt[8*b +: 8]      = wdata[8*b +: 8] & size[8*b +: 8];
      if (wr_hi && be[b]) base_nxt[32 + 8*b +: 8] = wdata[8*b +: 8] & size[32 + 8*b +: 8];
    end
    // Low nibble holds the read-only type/prefetch encoding, never a base bit.
    base_nxt[3:0] = 4'h0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      base <= '0;
    end else if (!unimpl) begin
      base <= base_nxt;
    end
  end

  assign rd_lo = unimpl ? 32'h0 : {base[31:4], prefetchable, BAR_TYPE_64, 1'b0};
  assign rd_hi = unimpl ? 32'h0 : base[63:32];

endmodule

// File: rtl/cfg_csh_bar_responder.sv
// Config-space responder for the type-0 header subset: serves host reads/writes,
// holds BAR bases and memory-space enable for downstream MMIO decode.
module cfg_csh_bar_responder
  import cfg_csh_bar_responder_pkg::*;
#(
  parameter int unsigned           ADDR_W    = 12,
  parameter logic [ADDR_W-1:0]     HDR_LIMIT = ADDR_W'(12'h03C)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_be,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_status,
  input  logic [63:0]       ro_bar0_size,
  input  logic [63:0]       ro_bar1_size,
  input  logic [63:0]       ro_bar2_size,
  input  logic              ro_bar0_prefetchable,
  input  logic              ro_bar1_prefetchable,
  input  logic              ro_bar2_prefetchable,
  input  logic [15:0]       ro_subsystem_id,
  input  logic [15:0]       ro_subsystem_vendor_id,
  input  logic [31:0]       ro_expansion_rom_bar,
  output logic [63:0]       cfg_bar0,
  output logic [63:0]       cfg_bar1,
  output logic [63:0]       cfg_bar2,
  output logic              cfg_mem_space_en
);

  csh_state_e        state, state_nxt;
  logic              accept;
  logic              wr_en;
  logic              unsup;
  logic [ADDR_W-1:0] addr_dw;
  logic [2:0]        wr_lo, wr_hi;
  logic [63:0]       bar_size [3];
  logic [2:0]        bar_pf;
  logic [63:0]       bar_base [3];
  logic [31:0]       bar_rd_lo [3];
  logic [31:0]       bar_rd_hi [3];
  logic [31:0]       rdata_nxt;
  logic [31:0]       rdata_p1;
  logic [1:0]        status_p1;
  logic              mem_en;

  function automatic logic is_addr(input logic [ADDR_W-1:0] a, input logic [11:0] c);
    return a == ADDR_W'(c);
  endfunction

  assign addr_dw = req_addr & ~ADDR_W'(3);
  assign unsup   = addr_dw > HDR_LIMIT;
  assign accept  = req_valid & req_ready;
  assign wr_en   = accept & req_wr & ~unsup;

  assign wr_lo = {wr_en & is_addr(addr_dw, CSH_BAR2_LO),
                  wr_en & is_addr(addr_dw, CSH_BAR1_LO),
                  wr_en & is_addr(addr_dw, CSH_BAR0_LO)};
  assign wr_hi = {wr_en & is_addr(addr_dw, CSH_BAR2_HI),
                  wr_en & is_addr(addr_dw, CSH_BAR1_HI),
                  wr_en & is_addr(addr_dw, CSH_BAR0_HI)};

  assign bar_size[0] = ro_bar0_size;
  assign bar_size[1] = ro_bar1_size;
  assign bar_size[2] = ro_bar2_size;
  assign bar_pf      = {ro_bar2_prefetchable, ro_bar1_prefetchable, ro_bar0_prefetchable};

  for (genvar g = 0; g < 3; g++) begin : g_bar
    cfg_csh_bar_reg u_bar (
      .clock        (clock),
      .reset        (reset),
      .size         (bar_size[g]),
      .prefetchable (bar_pf[g]),
      .wr_lo        (wr_lo[g]),
      .wr_hi        (wr_hi[g]),
      .be           (req_be),
      .wdata        (req_wdata),
      .base         (bar_base[g]),
      .rd_lo        (bar_rd_lo[g]),
      .rd_hi        (bar_rd_hi[g])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A new request is accepted in RESP only when the held response drains the same cycle.
  always_comb begin
    state_nxt  = state;
    resp_valid = 1'b0;
    req_ready  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ~reset;
        if (req_valid && req_ready) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        req_ready  = ~reset & resp_ready;
        if (resp_ready) state_nxt = req_valid ? RESP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdata_nxt = '0;
    if (!req_wr && !unsup) begin
      case (addr_dw)
        ADDR_W'(CSH_CMD):     rdata_nxt = {30'b0, mem_en, 1'b0};
        ADDR_W'(CSH_BAR0_LO): rdata_nxt = bar_rd_lo[0];
        ADDR_W'(CSH_BAR0_HI): rdata_nxt = bar_rd_hi[0];
        ADDR_W'(CSH_BAR1_LO): rdata_nxt = bar_rd_lo[1];
        ADDR_W'(CSH_BAR1_HI): rdata_nxt = bar_rd_hi[1];
        ADDR_W'(CSH_BAR2_LO): rdata_nxt = bar_rd_lo[2];
        ADDR_W'(CSH_BAR2_HI): rdata_nxt = bar_rd_hi[2];
        ADDR_W'(CSH_SUBSYS):  rdata_nxt = {ro_subsystem_id, ro_subsystem_vendor_id};
        ADDR_W'(CSH_EXP_ROM): rdata_nxt = ro_expansion_rom_bar;
        default:              rdata_nxt = '0;
      endcase
    end
  end

  // p1: registered response, held until consumed
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_p1  <= '0;
      status_p1 <= ST_OK;
      mem_en    <= 1'b0;
    end else begin
      if (accept) begin
        rdata_p1  <= rdata_nxt;
        status_p1 <= unsup ? ST_UNSUP : ST_OK;
      end
      if (wr_en && is_addr(addr_dw, CSH_CMD) && req_be[0]) mem_en <= req_wdata[1];
    end
  end

  assign resp_rdata       = rdata_p1;
  assign resp_status      = status_p1;
  assign cfg_bar0         = bar_base[0];
  assign cfg_bar1         = bar_base[1];
  assign cfg_bar2         = bar_base[2];
  assign cfg_mem_space_en = mem_en;

endmodule

// File: tb/tb_cfg_csh_bar_responder.sv
// Directed plus randomized bench for cfg_csh_bar_responder against a
// behavioural header model.
module tb_cfg_csh_bar_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wr;
  logic [11:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_status;
  logic [63:0] sz [3];
  logic        pf [3];
  logic [15:0] subsys_id, subsys_vid;
  logic [31:0] rom_bar;
  logic [63:0] cfg_bar0, cfg_bar1, cfg_bar2;
  logic        cfg_mem_space_en;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_bar [3];
  logic        m_mem;

  always #5 clock = ~clock;

  cfg_csh_bar_responder dut (
    .clock                  (clock),
    .reset                  (reset),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_wr                 (req_wr),
    .req_addr               (req_addr),
    .req_be                 (req_be),
    .req_wdata              (req_wdata),
    .resp_valid             (resp_valid),
    .resp_ready             (resp_ready),
    .resp_rdata             (resp_rdata),
    .resp_status            (resp_status),
    .ro_bar0_size           (sz[0]),
    .ro_bar1_size           (sz[1]),
    .ro_bar2_size           (sz[2]),
    .ro_bar0_prefetchable   (pf[0]),
    .ro_bar1_prefetchable   (pf[1]),
    .ro_bar2_prefetchable   (pf[2]),
    .ro_subsystem_id        (subsys_id),
    .ro_subsystem_vendor_id (subsys_vid),
    .ro_expansion_rom_bar   (rom_bar),
    .cfg_bar0               (cfg_bar0),
    .cfg_bar1               (cfg_bar1),
    .cfg_bar2               (cfg_bar2),
    .cfg_mem_space_en       (cfg_mem_space_en)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Header model: BAR n occupies dwords 0x10+8n (low) and 0x14+8n (high).
  function automatic logic [31:0] mdl_read(input logic [11:0] addr);
    int dw;
    int n;
    dw = int'(addr) & ~3;
    if (dw > 'h3C) return 32'h0;
    if (dw == 'h04) return m_mem ? 32'h2 : 32'h0;
    if (dw == 'h2C) return {subsys_id, subsys_vid};
    if (dw == 'h30) return rom_bar;
    if (dw >= 'h10 && dw <= 'h24) begin
      n = (dw - 'h10) / 8;
      if (sz[n] == 64'hFFFF_FFFF_FFFF_FFFF) return 32'h0;
      if (dw % 8 == 0) return (m_bar[n][31:0] & ~32'hF) | (pf[n] ? 32'h8 : 32'h0) | 32'h4;
      return m_bar[n][63:32];
    end
    return 32'h0;
  endfunction

  task automatic mdl_write(input logic [11:0] addr, input logic [3:0] be, input logic [31:0] wd);
    int dw;
    int n;
    logic [31:0] m;
    logic [63:0] s;
    dw = int'(addr) & ~3;
    m  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    if (dw > 'h3C) return;
    if (dw == 'h04 && be[0]) m_mem = wd[1];
    if (dw >= 'h10 && dw <= 'h24) begin
      n = (dw - 'h10) / 8;
      s = sz[n];
      if (s != 64'hFFFF_FFFF_FFFF_FFFF) begin
        if (dw % 8 == 0)
          m_bar[n][31:0] = ((m_bar[n][31:0] & ~m) | (wd & s[31:0] & m)) & ~32'hF;
        else
          m_bar[n][63:32] = (m_bar[n][63:32] & ~m) | (wd & s[63:32] & m);
      end
    end
  endtask

  task automatic check_cfg(input string tag);
    check({tag, "_bar0"}, cfg_bar0, m_bar[0]);
    check({tag, "_bar1"}, cfg_bar1, m_bar[1]);
    check({tag, "_bar2"}, cfg_bar2, m_bar[2]);
    check({tag, "_mem"}, {63'b0, cfg_mem_space_en}, {63'b0, m_mem});
  endtask

  // Starts just after a rising edge with the DUT idle; returns just after a rising edge.
  task automatic xact(input logic wr, input logic [11:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] got_d, output logic [1:0] got_s);
    logic [31:0] exp_d;
    logic [1:0]  exp_s;
    int n;
    exp_d = wr ? 32'h0 : mdl_read(addr);
    exp_s = ((int'(addr) & ~3) > 'h3C) ? 2'd1 : 2'd0;
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_be = be; req_wdata = wd;
    resp_ready = (hold == 0);
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", {63'b0, req_ready}, 64'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    if (wr) mdl_write(addr, be, wd);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check("hold_valid", {63'b0, resp_valid}, 64'd1);
      check("hold_rdata", {32'b0, resp_rdata}, {32'b0, exp_d});
      check("hold_ready", {63'b0, req_ready}, 64'd0);
      @(posedge clock); #1;
    end
    resp_ready = 1'b1;
    @(negedge clock);
    got_d = resp_rdata;
    got_s = resp_status;
    check("resp_valid", {63'b0, resp_valid}, 64'd1);
    check("resp_rdata", {32'b0, resp_rdata}, {32'b0, exp_d});
    check("resp_status", {62'b0, resp_status}, {62'b0, exp_s});
    check_cfg("cfg");
    @(posedge clock); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  s;
    logic [11:0] fa [4];
    logic [31:0] fexp [4];
    logic [11:0] ra;
    logic        rw;
    int          k;

    sz[0] = 64'hFFFF_FFFF_FC00_0000; pf[0] = 1'b0;
    sz[1] = 64'hFFFF_FFFF_FFFF_FFFF; pf[1] = 1'b1;
    sz[2] = 64'hFFFF_FFFF_FFFF_0000; pf[2] = 1'b1;
    subsys_id = 16'h0666; subsys_vid = 16'h1014; rom_bar = 32'hFFFF_F800;
    for (int i = 0; i < 3; i++) m_bar[i] = 64'h0;
    m_mem = 1'b0;
    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_be = '0;
    req_wdata = '0; resp_ready = 1'b1;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready", {63'b0, req_ready}, 64'd0);
    check("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    check("rst_rdata", {32'b0, resp_rdata}, 64'd0);
    check("rst_status", {62'b0, resp_status}, 64'd0);
    check("rst_bar0", cfg_bar0, 64'd0);
    check("rst_mem", {63'b0, cfg_mem_space_en}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // BAR sizing sequence
    xact(1'b1, 12'h010, 4'hF, 32'hFFFF_FFFF, 0, d, s);
    xact(1'b0, 12'h010, 4'hF, 32'h0, 0, d, s);
    check("size_lo", {32'b0, d}, 64'h0000_0000_FC00_0004);
    xact(1'b1, 12'h014, 4'hF, 32'hFFFF_FFFF, 0, d, s);
    xact(1'b0, 12'h014, 4'hF, 32'h0, 1, d, s);
    check("size_hi", {32'b0, d}, 64'h0000_0000_FFFF_FFFF);
    check("size_cfg_bar0", cfg_bar0, 64'hFFFF_FFFF_FC00_0000);

    // Byte enables
    xact(1'b1, 12'h010, 4'hF, 32'h0, 0, d, s);
    xact(1'b1, 12'h014, 4'hF, 32'h0, 0, d, s);
    xact(1'b1, 12'h010, 4'b1000, 32'h1234_5678, 0, d, s);
    xact(1'b0, 12'h010, 4'hF, 32'h0, 0, d, s);
    check("be_read", {32'b0, d}, 64'h0000_0000_1000_0004);
    check("be_cfg_bar0", cfg_bar0, 64'h0000_0000_1000_0000);

    // Unimplemented BAR1
    xact(1'b1, 12'h018, 4'hF, 32'hFFFF_FFFF, 0, d, s);
    xact(1'b0, 12'h018, 4'hF, 32'h0, 0, d, s);
    check("unimpl_lo", {32'b0, d}, 64'd0);
    xact(1'b0, 12'h01C, 4'hF, 32'h0, 0, d, s);
    check("unimpl_hi", {32'b0, d}, 64'd0);
    check("unimpl_cfg_bar1", cfg_bar1, 64'd0);

    // Decode
    xact(1'b0, 12'h02C, 4'hF, 32'h0, 0, d, s);
    check("subsys", {32'b0, d}, 64'h0000_0000_0666_1014);
    check("subsys_st", {62'b0, s}, 64'd0);
    xact(1'b0, 12'h030, 4'hF, 32'h0, 0, d, s);
    check("exp_rom", {32'b0, d}, 64'h0000_0000_FFFF_F800);
    xact(1'b0, 12'h100, 4'hF, 32'h0, 0, d, s);
    check("unsup_data", {32'b0, d}, 64'd0);
    check("unsup_st", {62'b0, s}, 64'd1);

    // Size change after write leaves stored base alone
    xact(1'b1, 12'h010, 4'hF, 32'hFFFF_FFFF, 0, d, s);
    sz[0] = 64'hFFFF_FFFF_FFFF_F000;
    @(posedge clock); #1;
    check("mask_at_write", cfg_bar0, 64'h0000_0000_FC00_0000);

    // Flow control: back-to-back reads with a stalled consumer
    fa[0] = 12'h02C; fa[1] = 12'h030; fa[2] = 12'h010; fa[3] = 12'h004;
    for (int i = 0; i < 4; i++) fexp[i] = mdl_read(fa[i]);
    req_wr = 1'b0; req_be = 4'hF; req_wdata = '0; resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = fa[0];
    @(posedge clock); #1;
    req_addr = fa[1];
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("fc_hold_valid", {63'b0, resp_valid}, 64'd1);
      check("fc_hold_rdata", {32'b0, resp_rdata}, {32'b0, fexp[0]});
      check("fc_hold_ready", {63'b0, req_ready}, 64'd0);
      @(posedge clock); #1;
    end
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("fc_valid", {63'b0, resp_valid}, 64'd1);
      check("fc_rdata", {32'b0, resp_rdata}, {32'b0, fexp[i]});
      @(posedge clock); #1;
      if (i < 2) req_addr = fa[i + 2];
      else       req_valid = 1'b0;
    end
    @(negedge clock);
    check("fc_drained", {63'b0, resp_valid}, 64'd0);
    @(posedge clock); #1;

    // Write command register then read it back-to-back
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 12'h004; req_be = 4'hF; req_wdata = 32'h2;
    @(posedge clock); #1;
    mdl_write(12'h004, 4'hF, 32'h2);
    req_wr = 1'b0;
    @(negedge clock);
    check("b2b_wr_rdata", {32'b0, resp_rdata}, 64'd0);
    check("b2b_ready", {63'b0, req_ready}, 64'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    check("b2b_rd_rdata", {32'b0, resp_rdata}, 64'd2);
    check("b2b_mem_en", {63'b0, cfg_mem_space_en}, 64'd1);
    @(posedge clock); #1;

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      k  = int'($urandom_range(0, 9));
      ra = (k == 0) ? 12'($urandom_range(12'h040, 12'hFFF)) : 12'($urandom_range(0, 12'h03F));
      rw = 1'($urandom_range(0, 1));
      xact(rw, ra, 4'($urandom), $urandom, int'($urandom_range(0, 2)), d, s);
    end

    // Reset during a pending response
    xact(1'b1, 12'h014, 4'hF, 32'hFFFF_FFFF, 0, d, s);
    check("pre_rst_bar0_nz", {63'b0, cfg_bar0 != 64'd0}, 64'd1);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 12'h010; resp_ready = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    check("pre_rst_valid", {63'b0, resp_valid}, 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_valid", {63'b0, resp_valid}, 64'd0);
    check("rst_mid_bar0", cfg_bar0, 64'd0);
    check("rst_mid_mem", {63'b0, cfg_mem_space_en}, 64'd0);
    check("rst_mid_ready", {63'b0, req_ready}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) m_bar[i] = 64'h0;
    m_mem = 1'b0;
    @(negedge clock);
    check("post_rst_ready", {63'b0, req_ready}, 64'd1);
    check("post_rst_valid", {63'b0, resp_valid}, 64'd0);
    @(posedge clock); #1;
    xact(1'b0, 12'h010, 4'hF, 32'h0, 0, d, s);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
